// File: rtl/text_cell_buffer.sv
// Text-mode cell store: host writes ASCII through valid/ready, the raster side reads glyph indices.
// Optional cursor blink overlay is enabled with the CURSOR_BLINK_EN macro.
module text_cell_buffer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 40,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 12,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_char,
    input  logic       clear_req,
    output logic       busy,
    input  logic [9:0] HorizontalCounter,
    input  logic [9:0] VerticalCounter,
    output logic [6:0] address,
    output logic [6:0] cursor_col,
    output logic [5:0] cursor_row
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [6:0]       LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]       LAST_ROW = 6'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] COLS_W   = IDX_W'(COLS);
    localparam logic [9:0]       H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);
    localparam logic [9:0]       CW       = 10'(CHAR_W);
    localparam logic [9:0]       CH       = 10'(CHAR_H);

    logic [6:0]       mem_q [CELLS];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [6:0]       col_q, col_d;
    logic [5:0]       row_q, row_d;
    logic [6:0]       addr_q, addr_d;

    logic             we;
    logic [IDX_W-1:0] wa;
    logic [6:0]       wd;
    logic             fire;
    logic             printable;
    logic [5:0]       next_row;
    logic [IDX_W-1:0] cur_idx;

    logic [9:0]       h_cell, v_cell;
    logic             in_range;
    logic [IDX_W-1:0] rd_idx;

    // A pending clear takes the cycle, so the host handshake is withheld.
    assign wr_ready   = (state_q == ST_IDLE) && !reset && !clear_req;
    assign fire       = wr_valid && wr_ready;
    assign busy       = (state_q == ST_CLEAR);
    assign printable  = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
    assign next_row   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
    assign cur_idx    = IDX_W'(row_q) * COLS_W + IDX_W'(col_q);
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign address    = addr_q;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        col_d     = col_q;
        row_d     = row_q;
        we        = 1'b0;
        wa        = cur_idx;
        wd        = 7'd0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else if (fire) begin
                    if (printable) begin
                        we = 1'b1;
                        wd = 7'(wr_char - 8'h20);
                        if (col_q == LAST_COL) begin
                            col_d = 7'd0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else if (wr_char == 8'h0D) begin
                        col_d = 7'd0;
                    end else if (wr_char == 8'h0A) begin
                        col_d = 7'd0;
                        row_d = next_row;
                    end else if (wr_char == 8'h08 && col_q != 7'd0) begin
                        col_d = col_q - 7'd1;
                        we    = 1'b1;
                        wa    = cur_idx - IDX_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                we = 1'b1;
                wa = clr_idx_q;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                    col_d     = 7'd0;
                    row_d     = 6'd0;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign h_cell   = HorizontalCounter / CW;
    assign v_cell   = VerticalCounter / CH;
    assign in_range = (HorizontalCounter < H_LIM) && (VerticalCounter < V_LIM);
    assign rd_idx   = IDX_W'(v_cell) * COLS_W + IDX_W'(h_cell);

`ifdef CURSOR_BLINK_EN
    localparam int FR_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_q;
    logic            phase_q;

    always_ff @(posedge clock50) begin
        if (reset) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else if (HorizontalCounter == 10'd0 && VerticalCounter == 10'd0) begin
            if (frame_q == LAST_FRAME) begin
                frame_q <= '0;
                phase_q <= !phase_q;
            end else begin
                frame_q <= frame_q + FR_W'(1);
            end
        end
    end

    always_comb begin
        addr_d = in_range ? mem_q[rd_idx] : 7'd0;
        if (phase_q && state_q == ST_IDLE && in_range && rd_idx == cur_idx) begin
            addr_d = 7'd63;
        end
    end
`else
    always_comb begin
        addr_d = in_range ? mem_q[rd_idx] : 7'd0;
    end
`endif

    // RAM has no reset; reads see the pre-write contents on a same-cell collision.
    always_ff @(posedge clock50) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            col_q     <= 7'd0;
            row_q     <= 6'd0;
            addr_q    <= 7'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
        end
    end

endmodule
